mdff_bank: RTL
==============

Name: mdff_bank

Overview:
- Parametrised successor to the single-bit multi-mode DFF primitive. Provides WIDTH flip-flops that share one configuration word.
- The configuration word selects:
  - clock-enable use and its polarity
  - sync set/reset use, its polarity and its value
  - parallel-register or shift-register mode
- The configuration is loaded through the scanchain on the same clock.
- Sits inside logic-block primitives as the techmap target for Yosys $dff/$dffe/$sdff/$sdffe cells and for packed shift registers.

Parameters:
- WIDTH, 4, number of flip-flops; legal range 1..64.
- CFG_BITS, 6, configuration word width. Fixed at 6; any other value is an elaboration error.

Ports:
- clk  input  1  single clock for data and configuration.
- rst  input  1  synchronous, active-high reset.
- cfg_e  input  1  configuration-shift enable.
- cfg_i  input  1  scanchain serial in.
- cfg_o  output  1  scanchain serial out, equal to cfg_q[5].
- D  input  WIDTH  parallel data in. In shift mode, D[0] is the serial in.
- ce  input  1  clock enable (raw; polarity is set by configuration).
- sr  input  1  set/reset request (raw; polarity is set by configuration).
- Q  output  WIDTH  registered data out.

Behaviour:
- Configuration register cfg_q[5:0] bit fields:
  - [0] en_ce
  - [1] ce_inv
  - [2] en_sr
  - [3] sr_inv
  - [4] sr_set
  - [5] shift_mode
- Reset: rst=1 at a clk rising edge gives Q=0 and cfg_q=0 on the next cycle.
  - cfg_q=0 is plain-DFF mode: always capture D.
  - cfg_o=0 after reset.
  - rst overrides cfg_e and all data activity, including mid-shift. A partial configuration load is discarded.
- Configuration shift:
  - While cfg_e=1 and rst=0, each edge does cfg_q <= {cfg_q[4:0], cfg_i}.
  - The first bit shifted in lands in cfg_q[5] after 6 edges.
  - cfg_o is cfg_q[5], so the chain latency is 6 cycles.
  - While cfg_e=1, Q holds its value regardless of D, ce and sr.
- Data path (cfg_e=0, rst=0), evaluated per edge:
  - ce_act = en_ce ? (ce ^ ce_inv) : 1
  - sr_act = en_sr & (sr ^ sr_inv)
- Update priority, highest first:
  1. rst
  2. sr_act: every Q bit <= sr_set. sr_act overrides ce_act, giving sync set/reset that does not depend on the enable.
  3. ce_act=0: Q holds.
  4. shift_mode=0: Q <= D.
  5. shift_mode=1: Q <= {Q[WIDTH-2:0], D[0]}. D[WIDTH-1:1] are ignored. With WIDTH=1 this reduces to Q <= D[0].
- Latency: D to Q is 1 cycle. There is no combinational path from any input to Q or cfg_o.
- A configuration change takes effect on the edge after the shift cycle that completes it. Q is not cleared when the configuration changes.
- Simultaneous events: cfg_e=1 together with sr_act=1 means the configuration shifts and Q holds; sr is ignored.
- Unused configuration combinations are legal:
  - en_ce=0 with ce_inv=1: ce_inv is ignored.
  - en_sr=0: sr_inv and sr_set are ignored.

Test Plan:
- Reset/plain DFF: WIDTH=4. Assert rst for 1 cycle, then drive D=4'hA, 4'h5 on consecutive cycles. Required: after reset Q=0 and cfg_o=0; then Q=A, then Q=5, each 1 cycle after D.
- Config shift and passthrough:
  - Shift cfg_i bits 1,0,1,1,0,1 over 6 cycles, which gives cfg_q=6'b101101 (shift, sr_inv, en_sr, en_ce).
  - Required: Q stays at 4'h3 throughout.
  - Then shift 6 more zeros; cfg_o must emit 1,0,1,1,0,1 in that order.
- CE polarity:
  - Configure en_ce=1, ce_inv=1.
  - Drive D=4'hF with ce=1: Q holds 0.
  - Drive ce=0: Q=F next cycle.
- SR priority:
  - Configure en_ce=1, en_sr=1, sr_set=1, sr_inv=0, with Q=4'h2.
  - Drive sr=1, ce=0 (inactive) and D=4'h0: Q=4'hF next cycle.
  - Then set sr_set=0 and pulse sr: Q=4'h0.
- Shift mode:
  - Configure shift_mode=1 with cfg_q=6'b100000.
  - Drive D[0]=1,0,1,1 on consecutive cycles from Q=0: Q=4'b0001, 0010, 0101, 1011.
- Reset mid-operation:
  - Assert rst after 3 of 6 configuration bits.
  - Required: cfg_o=0 and Q=0.
  - The next D=4'h9 is captured plainly, giving Q=9.

Source files
------------

// File: rtl/mdff_bank_if.sv
// Data and scanchain signals of an mdff_bank. clk and rst are separate ports.
// The master drives D, ce, sr and the scanchain input. The slave returns Q and cfg_o.
interface mdff_bank_if #(
  parameter int WIDTH = 4
);
  logic             cfg_e;
  logic             cfg_i;
  logic             cfg_o;
  logic [WIDTH-1:0] D;
  logic             ce;
  logic             sr;
  logic [WIDTH-1:0] Q;

  modport master (
    output cfg_e, cfg_i, D, ce, sr,
    input  cfg_o, Q
  );

  modport slave (
    input  cfg_e, cfg_i, D, ce, sr,
    output cfg_o, Q
  );
endinterface

// File: rtl/mdff_bank.sv
// Bank of WIDTH flip-flops sharing one scan-loaded mode word: enable, sync set/reset, DFF or shift mode.
// D to Q takes 1 cycle, and the 6-bit scanchain also takes 1 cycle per bit. There is no backpressure, and Q holds while cfg_e=1.
module mdff_bank #(
  parameter int WIDTH    = 4,
  parameter int CFG_BITS = 6
) (
  input logic        clk,
  input logic        rst,
  mdff_bank_if.slave bus
);

  if (CFG_BITS != 6) begin : g_bad_cfg_bits
    $error("mdff_bank: CFG_BITS must be 6");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("mdff_bank: WIDTH must be in 1..64");
  end

  logic [5:0]       cfg_q;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shift_val;
  logic             en_ce, ce_inv, en_sr, sr_inv, sr_set, shift_mode;
  logic             ce_act, sr_act;

  assign {shift_mode, sr_set, sr_inv, en_sr, ce_inv, en_ce} = cfg_q;

  // When a feature is disabled, its polarity and value bits have no effect.
  assign ce_act = en_ce ? (bus.ce ^ ce_inv) : 1'b1;
  assign sr_act = en_sr & (bus.sr ^ sr_inv);

  if (WIDTH == 1) begin : g_shift_one
    assign shift_val = bus.D[0];
  end else begin : g_shift_many
    assign shift_val = {q_r[WIDTH-2:0], bus.D[0]};
  end

  // Update priority: rst, then a config shift that freezes Q, then sr, then ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      q_r   <= '0;
    end else if (bus.cfg_e) begin
      cfg_q <= {cfg_q[4:0], bus.cfg_i};
    end else if (sr_act) begin
      q_r <= {WIDTH{sr_set}};
    end else if (ce_act) begin
      q_r <= shift_mode ? shift_val : bus.D;
    end
  end

  assign bus.Q     = q_r;
  assign bus.cfg_o = cfg_q[5];

endmodule
